pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS-lite pipeline.
- Drives the write-enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves load-use hazards, taken-branch flushes and data-memory wait states.
- Runs a small FSM that times out a hung memory access, plus saturating performance counters.

Parameters:
- MEM_TIMEOUT, 16, max consecutive wait cycles before the controller halts the pipe; legal range 1..255.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_Memread  in  1  instruction in EX is a load.
- ex_rt  in  5  load destination register in EX.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- mem_req  in  1  MEM-stage instruction accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_wen  out  1  PC update enable.
- ifid_wen  out  1  IF/ID enable.
- ifid_flush  out  1  IF/ID flush.
- idex_wen  out  1  ID/EX enable.
- idex_flush  out  1  ID/EX flush (bubble insert).
- exmem_wen  out  1  EX/MEM enable.
- memwb_flush  out  1  bubble into MEM/WB.
- mem_err  out  1  sticky: memory timeout occurred, pipe halted.
- stall_cnt  out  CNT_W  cycles lost to stalls.
- flush_cnt  out  CNT_W  taken-branch flush events.

Behaviour:
- FSM states: RUN, WAIT, HALT. Reset state is RUN.
- Reset values: state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0, flush_cnt=0.
- While rst is high: all *_wen=0, ifid_flush=1, idex_flush=1, memwb_flush=1.
- Reset asserted mid-WAIT or in HALT returns to RUN immediately (asynchronous).
- Control outputs are combinational from the inputs and state; there is no added latency.
- Signal definitions:
  - freeze = mem_req & !mem_ready (any state except HALT).
  - lu = ex_Memread & ex_rt!=0 & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
- Priority: HALT > freeze > branch > load-use > normal.
  - HALT: all wen=0, all flushes=0. The pipe holds forever.
  - freeze: all wen=0, all flushes 0 except memwb_flush=1. The branch and load-use conditions are held and re-evaluated after the freeze.
  - branch: all wen=1, ifid_flush=1, idex_flush=1. Load-use is ignored because the ID instruction is wrong-path.
  - load-use: pc_wen=0, ifid_wen=0, idex_flush=1, idex_wen=1, exmem_wen=1.
  - normal: all wen=1, all flushes=0.
- FSM transitions:
  - RUN: on freeze go to WAIT with wait_cnt=1. Otherwise stay in RUN.
  - WAIT, mem_ready=1: go to RUN, wait_cnt=0. The pipe advances in that same cycle.
  - WAIT, freeze and wait_cnt==MEM_TIMEOUT: go to HALT and set mem_err=1.
  - WAIT, freeze otherwise: wait_cnt+1.
  - WAIT, mem_req dropped: go to RUN.
  - HALT: exits only by reset.
- mem_ready without mem_req is ignored.
- Counters:
  - stall_cnt += 1 on each cycle with freeze or load-use active (not in HALT).
  - flush_cnt += 1 on each branch-flush cycle.
  - Both counters saturate at all-ones; there is no wrap-around.
- A branch and load-use in the same cycle count toward flush_cnt only.

Test Plan:
- Load-use: ex_Memread=1, ex_rt=8, id_rs=8, id_uses_rs=1 for 1 cycle -> pc_wen=0, ifid_wen=0, idex_flush=1 for exactly that cycle; stall_cnt 0->1.
- $zero and unused operand: ex_Memread=1, ex_rt=0, id_rs=0; then ex_rt=9, id_rt=9, id_uses_rt=0 -> no stall in either cycle; all wen=1.
- Branch priority: ex_branch_taken=1 with the load-use condition also true -> ifid_flush=1, idex_flush=1, pc_wen=1; flush_cnt=1, stall_cnt unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> all wen=0 and memwb_flush=1 for 3 cycles; state WAIT; all wen=1 on the 4th cycle; stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ready held 0 -> HALT entered after the 4th WAIT cycle; mem_err=1 and all outputs frozen; later mem_ready=1 has no effect.
- Async reset: assert rst mid-WAIT between clock edges -> outputs go to reset values immediately; after release, state=RUN, counters=0, mem_err=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch flush, memory wait, timeout halt.
// Control outputs are combinational from inputs and state; counters and FSM update on the clock.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_Memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_wen,
  output logic             ifid_wen,
  output logic             ifid_flush,
  output logic             idex_wen,
  output logic             idex_flush,
  output logic             exmem_wen,
  output logic             memwb_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;
  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic halt, freeze, lu, stall_inc, flush_inc;

  assign halt   = (state_q == ST_HALT);
  assign freeze = mem_req & ~mem_ready & ~halt;
  assign lu     = ex_Memread & (ex_rt != 5'd0) &
                  ((id_uses_rs & (id_rs == ex_rt)) | (id_uses_rt & (id_rt == ex_rt)));

  // A branch in the same cycle as load-use wins: the ID instruction is wrong-path.
  assign stall_inc = ~halt & (freeze | (lu & ~ex_branch_taken));
  assign flush_inc = ~halt & ~freeze & ex_branch_taken;

  always_comb begin
    pc_wen      = 1'b1;
    ifid_wen    = 1'b1;
    ifid_flush  = 1'b0;
    idex_wen    = 1'b1;
    idex_flush  = 1'b0;
    exmem_wen   = 1'b1;
    memwb_flush = 1'b0;
    if (rst) begin
      pc_wen      = 1'b0;
      ifid_wen    = 1'b0;
      idex_wen    = 1'b0;
      exmem_wen   = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end else if (halt) begin
      pc_wen    = 1'b0;
      ifid_wen  = 1'b0;
      idex_wen  = 1'b0;
      exmem_wen = 1'b0;
    end else if (freeze) begin
      pc_wen      = 1'b0;
      ifid_wen    = 1'b0;
      idex_wen    = 1'b0;
      exmem_wen   = 1'b0;
      memwb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu) begin
      pc_wen     = 1'b0;
      ifid_wen   = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      ST_RUN: begin
        if (freeze) begin
          state_d    = ST_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      ST_WAIT: begin
        if (freeze) begin
          if (wait_cnt_q == TIMEOUT) begin
            state_d   = ST_HALT;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = 8'd0;
      end
    endcase

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_inc && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= 8'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table plus hand-built wait/timeout/reset sequences.
module tb_pipe_hazard_ctrl;

  localparam int CW = 8;
  localparam logic [6:0] C_NRM = 7'b1101010;
  localparam logic [6:0] C_LU  = 7'b0001110;
  localparam logic [6:0] C_BR  = 7'b1111110;
  localparam logic [6:0] C_FZ  = 7'b0000001;
  localparam logic [6:0] C_HLT = 7'b0000000;
  localparam logic [6:0] C_RST = 7'b0010101;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic id_uses_rs = 0, id_uses_rt = 0, ex_Memread = 0, ex_branch_taken = 0;
  logic mem_req = 0, mem_ready = 0;
  logic pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen, memwb_flush, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [6:0] ctl;

  int n_chk = 0;
  int n_fail = 0;
  logic [CW-1:0] exp_stall = '0, exp_flush = '0;
  logic exp_err = 1'b0;

  typedef struct {
    string nm;
    logic [4:0] rs, rt, xrt;
    logic urs, urt, mrd, br, mreq, mrdy;
    logic [6:0] ctl;
    logic sinc, finc;
  } vec_t;

  typedef struct {
    logic [CW-1:0] stall, flush;
    logic err;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[13];

  always #5 clk = ~clk;

  assign ctl = {pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen, memwb_flush};

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_Memread(ex_Memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_wen(pc_wen), .ifid_wen(ifid_wen), .ifid_flush(ifid_flush),
    .idex_wen(idex_wen), .idex_flush(idex_flush), .exmem_wen(exmem_wen),
    .memwb_flush(memwb_flush), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic vec_t mk(string nm, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                              logic mrd, logic [4:0] xrt, logic br, logic mreq, logic mrdy,
                              logic [6:0] c, logic sinc, logic finc);
    vec_t v;
    v.nm = nm; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mrd = mrd; v.xrt = xrt;
    v.br = br; v.mreq = mreq; v.mrdy = mrdy; v.ctl = c; v.sinc = sinc; v.finc = finc;
    return v;
  endfunction

  function automatic logic [CW-1:0] sat_inc(logic [CW-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input vec_t v, input logic err_after);
    exp_t e;
    id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
    ex_Memread = v.mrd; ex_rt = v.xrt; ex_branch_taken = v.br;
    mem_req = v.mreq; mem_ready = v.mrdy;
    if (v.sinc) exp_stall = sat_inc(exp_stall);
    if (v.finc) exp_flush = sat_inc(exp_flush);
    exp_err = err_after;
    sb.push_back('{stall: exp_stall, flush: exp_flush, err: exp_err});
    #3;
    chk({v.nm, " ctl"}, 32'(ctl), 32'(v.ctl));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({v.nm, " stall_cnt"}, 32'(stall_cnt), 32'(e.stall));
    chk({v.nm, " flush_cnt"}, 32'(flush_cnt), 32'(e.flush));
    chk({v.nm, " mem_err"}, 32'(mem_err), 32'(e.err));
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    {ex_Memread, ex_branch_taken, mem_req, mem_ready, id_uses_rs, id_uses_rt} = '0;
    #2;
    chk({nm, " rst ctl"}, 32'(ctl), 32'(C_RST));
    chk({nm, " rst stall_cnt"}, 32'(stall_cnt), 0);
    chk({nm, " rst flush_cnt"}, 32'(flush_cnt), 0);
    chk({nm, " rst mem_err"}, 32'(mem_err), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_stall = '0; exp_flush = '0; exp_err = 1'b0;
  endtask

  initial begin
    vec_t nrm, fz, fz_br, rdy_br, lu8, br;
    nrm    = mk("normal",   0, 0, 0, 0, 0, 0, 0, 0, 0, C_NRM, 0, 0);
    fz     = mk("freeze",   0, 0, 0, 0, 0, 0, 0, 1, 0, C_FZ,  1, 0);
    fz_br  = mk("frz_br",   8, 0, 1, 0, 1, 8, 1, 1, 0, C_FZ,  1, 0);
    rdy_br = mk("rdy_br",   8, 0, 1, 0, 1, 8, 1, 1, 1, C_BR,  0, 1);
    lu8    = mk("lu_sat",   8, 0, 1, 0, 1, 8, 0, 0, 0, C_LU,  1, 0);
    br     = mk("br_sat",   0, 0, 0, 0, 0, 0, 1, 0, 0, C_BR,  0, 1);

    tbl[0]  = nrm;
    tbl[1]  = mk("lu_rs",      8, 0, 1, 0, 1, 8, 0, 0, 0, C_LU,  1, 0);
    tbl[2]  = mk("zero_reg",   0, 0, 1, 0, 1, 0, 0, 0, 0, C_NRM, 0, 0);
    tbl[3]  = mk("unused_rt",  0, 9, 0, 0, 1, 9, 0, 0, 0, C_NRM, 0, 0);
    tbl[4]  = mk("lu_rt",      0, 9, 0, 1, 1, 9, 0, 0, 0, C_LU,  1, 0);
    tbl[5]  = mk("no_load",    8, 8, 1, 1, 0, 8, 0, 0, 0, C_NRM, 0, 0);
    tbl[6]  = mk("rs_miss",    7, 6, 1, 1, 1, 8, 0, 0, 0, C_NRM, 0, 0);
    tbl[7]  = mk("br_over_lu", 8, 0, 1, 0, 1, 8, 1, 0, 0, C_BR,  0, 1);
    tbl[8]  = mk("br_only",    0, 0, 0, 0, 0, 0, 1, 0, 0, C_BR,  0, 1);
    tbl[9]  = mk("rdy_no_req", 0, 0, 0, 0, 0, 0, 0, 0, 1, C_NRM, 0, 0);
    tbl[10] = mk("req_rdy",    0, 0, 0, 0, 0, 0, 0, 1, 1, C_NRM, 0, 0);
    tbl[11] = mk("req_rdy_lu", 31, 0, 1, 0, 1, 31, 0, 1, 1, C_LU, 1, 0);
    tbl[12] = mk("lu_both",    5, 5, 1, 1, 1, 5, 0, 0, 0, C_LU,  1, 0);

    #2;
    chk("init ctl", 32'(ctl), 32'(C_RST));
    chk("init stall_cnt", 32'(stall_cnt), 0);
    chk("init flush_cnt", 32'(flush_cnt), 0);
    chk("init mem_err", 32'(mem_err), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 13; i++) step(tbl[i], 1'b0);

    // Memory wait: three frozen cycles, then the access completes and the pipe advances.
    for (int i = 0; i < 3; i++) step(fz, 1'b0);
    step(mk("wait_done", 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NRM, 0, 0), 1'b0);

    // A branch held under a freeze is acted on only once memory is ready.
    step(fz_br, 1'b0);
    step(fz_br, 1'b0);
    step(rdy_br, 1'b0);
    step(mk("req_drop", 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NRM, 0, 0), 1'b0);

    do_reset("sat");
    for (int i = 0; i < 260; i++) step(lu8, 1'b0);
    for (int i = 0; i < 260; i++) step(br, 1'b0);
    chk("stall saturated", 32'(stall_cnt), 32'hFF);
    chk("flush saturated", 32'(flush_cnt), 32'hFF);

    // Asynchronous reset asserted between edges while waiting on memory.
    do_reset("pre_async");
    step(fz, 1'b0);
    mem_req = 1'b1; mem_ready = 1'b0;
    #2;
    chk("mid_wait ctl", 32'(ctl), 32'(C_FZ));
    rst = 1'b1;
    #1;
    chk("async ctl", 32'(ctl), 32'(C_RST));
    chk("async stall_cnt", 32'(stall_cnt), 0);
    chk("async mem_err", 32'(mem_err), 0);
    @(posedge clk);
    #1;
    mem_req = 1'b0;
    rst = 1'b0;
    exp_stall = '0; exp_flush = '0; exp_err = 1'b0;
    step(nrm, 1'b0);

    // Timeout: one RUN freeze cycle, then WAIT counts 1..4 and halts on the 4th.
    for (int i = 0; i < 4; i++) step(fz, 1'b0);
    step(fz, 1'b1);
    step(mk("halt_rdy", 8, 0, 1, 0, 1, 8, 1, 1, 1, C_HLT, 0, 0), 1'b1);
    step(mk("halt_br",  0, 0, 0, 0, 0, 0, 1, 0, 0, C_HLT, 0, 0), 1'b1);
    step(mk("halt_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, C_HLT, 0, 0), 1'b1);

    do_reset("halt_exit");
    step(nrm, 1'b0);
    step(tbl[1], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
